// File: rtl/vx_dispatch_lane_seq.sv
// Dispatch receiver: latches one warp-wide packet and replays it as NUM_LANES-wide batches,
// skipping batches whose thread mask slice is empty.

module vx_dispatch_lane_mux #(
    parameter int NB    = 2,
    parameter int XLEN  = 32,
    parameter int PID_W = 1
) (
    input  logic [PID_W-1:0]         pid,
    input  logic [NB-1:0]            tmask_col,
    input  logic [NB-1:0][XLEN-1:0]  rs1_col,
    input  logic [NB-1:0][XLEN-1:0]  rs2_col,
    input  logic [NB-1:0][XLEN-1:0]  rs3_col,
    output logic                     lane_tmask,
    output logic [XLEN-1:0]          lane_rs1,
    output logic [XLEN-1:0]          lane_rs2,
    output logic [XLEN-1:0]          lane_rs3
);
    assign lane_tmask = tmask_col[pid];
    assign lane_rs1   = rs1_col[pid];
    assign lane_rs2   = rs2_col[pid];
    assign lane_rs3   = rs3_col[pid];
endmodule

module vx_dispatch_lane_seq #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int HDR_W       = 64,
    localparam int NB         = NUM_THREADS / NUM_LANES,
    localparam int PID_W      = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [HDR_W-1:0]              in_hdr,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs2_data,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs3_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [HDR_W-1:0]              out_hdr,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [NUM_LANES*XLEN-1:0]     out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]     out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]     out_rs3_data,
    output logic [PID_W-1:0]              out_pid,
    output logic                          out_sop,
    output logic                          out_eop,
    input  logic                          out_ready
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_n;
    logic [NB-1:0] pend, pend_n, pend_in, cur_oh;
    logic sop, sop_n, load, eop, fire_out, accept;
    logic [PID_W-1:0] cur_pid;
    logic [HDR_W-1:0] hdr_r;
    logic [NB-1:0][NUM_LANES-1:0] tmask_r;
    logic [NB-1:0][NUM_LANES-1:0][XLEN-1:0] rs1_r, rs2_r, rs3_r;

    assign out_valid = (state == BUSY);
    assign eop       = ((pend & (pend - NB'(1))) == '0);
    assign out_eop   = out_valid & eop;
    assign out_sop   = out_valid & sop;
    assign fire_out  = out_valid & out_ready;
    // Taking a new packet in the eop handshake cycle keeps the unit streaming without bubbles.
    assign in_ready  = ~reset & (~out_valid | (fire_out & eop));
    assign accept    = in_valid & in_ready;
    assign cur_oh    = pend & (~pend + NB'(1));
    assign out_pid   = cur_pid;
    assign out_hdr   = hdr_r;

    always_comb begin
        cur_pid = '0;
        for (int b = NB - 1; b >= 0; b--)
            if (pend[b]) cur_pid = PID_W'(b);
    end

    // An all-zero mask still produces one (empty) batch so the packet retires.
    always_comb begin
        pend_in = '0;
        for (int b = 0; b < NB; b++)
            pend_in[b] = |in_tmask[b*NUM_LANES +: NUM_LANES];
        if (pend_in == '0) pend_in = NB'(1);
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        sop_n   = sop;
        load    = 1'b0;
        if (fire_out) begin
            pend_n = pend & ~cur_oh;
            sop_n  = 1'b0;
            if (eop) state_n = IDLE;
        end
        if (accept) begin
            load    = 1'b1;
            state_n = BUSY;
            pend_n  = pend_in;
            sop_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pend    <= '0;
            sop     <= 1'b0;
            hdr_r   <= '0;
            tmask_r <= '0;
            rs1_r   <= '0;
            rs2_r   <= '0;
            rs3_r   <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            sop   <= sop_n;
            if (load) begin
                hdr_r   <= in_hdr;
                tmask_r <= in_tmask;
                rs1_r   <= in_rs1_data;
                rs2_r   <= in_rs2_data;
                rs3_r   <= in_rs3_data;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [NB-1:0]           t_col;
        logic [NB-1:0][XLEN-1:0] c1, c2, c3;
        for (genvar b = 0; b < NB; b++) begin : g_col
            assign t_col[b] = tmask_r[b][l];
            assign c1[b]    = rs1_r[b][l];
            assign c2[b]    = rs2_r[b][l];
            assign c3[b]    = rs3_r[b][l];
        end
        vx_dispatch_lane_mux #(.NB(NB), .XLEN(XLEN), .PID_W(PID_W)) u_lane (
            .pid        (cur_pid),
            .tmask_col  (t_col),
            .rs1_col    (c1),
            .rs2_col    (c2),
            .rs3_col    (c3),
            .lane_tmask (out_tmask[l]),
            .lane_rs1   (out_rs1_data[l*XLEN +: XLEN]),
            .lane_rs2   (out_rs2_data[l*XLEN +: XLEN]),
            .lane_rs3   (out_rs3_data[l*XLEN +: XLEN])
        );
    end
endmodule

// File: tb/tb_vx_dispatch_lane_seq.sv
// Directed bench for vx_dispatch_lane_seq (NUM_THREADS=4, NUM_LANES=2).

module tb_vx_dispatch_lane_seq;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [63:0]  in_hdr;
    logic [3:0]   in_tmask;
    logic [127:0] in_rs1_data, in_rs2_data, in_rs3_data;
    logic         in_ready, out_valid, out_sop, out_eop, out_ready;
    logic [63:0]  out_hdr;
    logic [1:0]   out_tmask;
    logic [63:0]  out_rs1_data, out_rs2_data, out_rs3_data;
    logic [0:0]   out_pid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vx_dispatch_lane_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_hdr(in_hdr), .in_tmask(in_tmask),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_hdr(out_hdr), .out_tmask(out_tmask),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
        .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] mk(input int base);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = 32'(base + i);
        return v;
    endfunction

    function automatic logic [63:0] pr(input int hi, input int lo);
        return {32'(hi), 32'(lo)};
    endfunction

    task automatic offer(input logic [3:0] m, input int base);
        in_valid    = 1'b1;
        in_tmask    = m;
        in_hdr      = 64'hC0DE_0000_0000_0000 | 64'(base);
        in_rs1_data = mk(base);
        in_rs2_data = mk(base + 10);
        in_rs3_data = mk(base + 20);
    endtask

    task automatic batch(input string tag, input int pid, input logic [1:0] tm,
                         input int b0, input int b1, input bit sop, input bit eop);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".pid"},   64'(out_pid),   64'(pid));
        chk({tag, ".tmask"}, 64'(out_tmask), 64'(tm));
        chk({tag, ".rs1"},   out_rs1_data,   pr(b1, b0));
        chk({tag, ".rs3"},   out_rs3_data,   pr(b1 + 20, b0 + 20));
        chk({tag, ".sop"},   64'(out_sop),   64'(sop));
        chk({tag, ".eop"},   64'(out_eop),   64'(eop));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_tmask = '0; in_hdr = '0; in_rs1_data = '0; in_rs2_data = '0; in_rs3_data = '0;
        tick(); tick();
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.ready", 64'(in_ready), 64'd0);
        chk("rst.pid",   64'(out_pid), 64'd0);
        chk("rst.sop",   64'(out_sop), 64'd0);
        chk("rst.eop",   64'(out_eop), 64'd0);
        chk("rst.rs1",   out_rs1_data, 64'd0);
        reset = 1'b0;
        #1 chk("idle.ready", 64'(in_ready), 64'd1);

        // full mask: two batches back-to-back
        offer(4'b1111, 0);
        tick(); in_valid = 1'b0;
        batch("t1.b0", 0, 2'b11, 0, 1, 1, 0);
        chk("t1.hdr", out_hdr, 64'hC0DE_0000_0000_0000);
        chk("t1.rs2", out_rs2_data, pr(11, 10));
        chk("t1.rdy0", 64'(in_ready), 64'd0);
        tick();
        batch("t1.b1", 1, 2'b11, 2, 3, 0, 1);
        chk("t1.rdy1", 64'(in_ready), 64'd1);
        tick();
        chk("t1.done", 64'(out_valid), 64'd0);

        // upper half only: batch 0 skipped
        offer(4'b1100, 40);
        tick(); in_valid = 1'b0;
        batch("t2", 1, 2'b11, 42, 43, 1, 1);
        tick();
        chk("t2.done", 64'(out_valid), 64'd0);

        // empty mask: single empty batch 0
        offer(4'b0000, 60);
        tick(); in_valid = 1'b0;
        batch("t3", 0, 2'b00, 60, 61, 1, 1);
        tick();
        chk("t3.done", 64'(out_valid), 64'd0);
        chk("t3.ready", 64'(in_ready), 64'd1);

        // mixed mask {lane3, lane0}: both batches, partial tmask each
        offer(4'b1001, 70);
        tick(); in_valid = 1'b0;
        batch("t3b.b0", 0, 2'b01, 70, 71, 1, 0);
        tick();
        batch("t3b.b1", 1, 2'b10, 72, 73, 0, 1);
        tick();

        // stall on pid0 for three cycles
        offer(4'b1111, 80);
        out_ready = 1'b0;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            batch("t4.hold", 0, 2'b11, 80, 81, 1, 0);
            chk("t4.rdy", 64'(in_ready), 64'd0);
            tick();
        end
        batch("t4.hold3", 0, 2'b11, 80, 81, 1, 0);
        out_ready = 1'b1;
        tick();
        batch("t4.b1", 1, 2'b11, 82, 83, 0, 1);
        tick();
        chk("t4.done", 64'(out_valid), 64'd0);

        // two packets back-to-back, no idle cycle between them
        offer(4'b1111, 100);
        tick();
        offer(4'b1111, 200);
        batch("t5.a0", 0, 2'b11, 100, 101, 1, 0);
        chk("t5.rdyA0", 64'(in_ready), 64'd0);
        tick();
        batch("t5.a1", 1, 2'b11, 102, 103, 0, 1);
        chk("t5.rdyA1", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        batch("t5.b0", 0, 2'b11, 200, 201, 1, 0);
        chk("t5.hdrB", out_hdr, 64'hC0DE_0000_0000_00C8);
        tick();
        batch("t5.b1", 1, 2'b11, 202, 203, 0, 1);
        tick();
        chk("t5.done", 64'(out_valid), 64'd0);

        // reset while busy at pid0
        offer(4'b1111, 300);
        tick(); in_valid = 1'b0;
        batch("t6.pre", 0, 2'b11, 300, 301, 1, 0);
        reset = 1'b1;
        tick();
        chk("t6.valid", 64'(out_valid), 64'd0);
        chk("t6.ready", 64'(in_ready), 64'd0);
        chk("t6.sop",   64'(out_sop), 64'd0);
        reset = 1'b0;
        offer(4'b1111, 400);
        tick(); in_valid = 1'b0;
        batch("t6.post", 0, 2'b11, 400, 401, 1, 0);
        tick();
        batch("t6.post1", 1, 2'b11, 402, 403, 0, 1);
        tick();
        chk("t6.done", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
